reimu_bullet: RTL and testbench

REIMU_BULLET -- requirements
Module: reimu_bullet

---
 rtl/reimu_bullet.sv | 110 +++++++++++
 tb/tb_reimu_bullet.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/reimu_bullet.sv
// reimu_bullet: four-slot player bullet pool with fire cooldown, enemy collision and hit pulses.
// Optional hit score counter enabled by defining REIMU_BULLET_SCORE_EN.
module reimu_bullet #(
  parameter logic [9:0] SPEED = 10'd12,
  parameter logic [3:0] COOLDOWN = 4'd4
) (
  input  logic        clk22,
  input  logic        rst,
  input  logic        fire,
  input  logic [9:0]  reimux,
  input  logic [9:0]  reimuy,
  input  logic [9:0]  enmx1,
  input  logic [9:0]  enmx2,
  input  logic [9:0]  enmx3,
  input  logic [9:0]  enmx4,
  input  logic [9:0]  enmy1,
  input  logic [9:0]  enmy2,
  input  logic [9:0]  enmy3,
  input  logic [9:0]  enmy4,
  input  logic        enm1,
  input  logic        enm2,
  input  logic        enm3,
  input  logic        enm4,
  output logic [9:0]  bulletx1,
  output logic [9:0]  bulletx2,
  output logic [9:0]  bulletx3,
  output logic [9:0]  bulletx4,
  output logic [9:0]  bullety1,
  output logic [9:0]  bullety2,
  output logic [9:0]  bullety3,
  output logic [9:0]  bullety4,
  output logic [3:0]  bullet_vld,
  output logic        hit1,
  output logic        hit2,
  output logic        hit3,
  output logic        hit4,
  output logic [15:0] score
);
  logic [9:0] bx [4];
  logic [9:0] by [4];
  logic [9:0] ex [4];
  logic [9:0] ey [4];
  logic [3:0] vld, cd, hit, hit_n, ea, hs, ret, free, sel;
  logic [3:0] ovl [4];
  logic [3:0] strike [4];
  logic acc;
  assign ex = '{enmx1, enmx2, enmx3, enmx4};
  assign ey = '{enmy1, enmy2, enmy3, enmy4};
  assign ea = {enm4, enm3, enm2, enm1};
  assign {bulletx4, bulletx3, bulletx2, bulletx1} = {bx[3], bx[2], bx[1], bx[0]};
  assign {bullety4, bullety3, bullety2, bullety1} = {by[3], by[2], by[1], by[0]};
  assign bullet_vld = vld;
  assign {hit4, hit3, hit2, hit1} = hit;
  assign free = ~vld;
  assign sel = free & (~free + 4'd1);
  assign acc = fire && cd == 4'd0 && reimuy >= 10'd24 && |free;
  // Box test is rearranged as x+12 > e and x < e+12 in 11 bits so small enemy coordinates never wrap
  always_comb begin
    hit_n = '0;
    for (int i = 0; i < 4; i++) begin
      ovl[i] = '0;
      for (int k = 0; k < 4; k++)
        ovl[i][k] = vld[i] && ea[k]
          && ({1'b0, bx[i]} + 11'd12 > {1'b0, ex[k]}) && ({1'b0, bx[i]} < {1'b0, ex[k]} + 11'd12)
          && ({1'b0, by[i]} + 11'd12 > {1'b0, ey[k]}) && ({1'b0, by[i]} < {1'b0, ey[k]} + 11'd12);
      strike[i] = ovl[i] & (~ovl[i] + 4'd1);
      hs[i] = |ovl[i];
      ret[i] = vld[i] && !hs[i] && ({1'b0, by[i]} < {1'b0, SPEED} + 11'd8);
      hit_n = hit_n | strike[i];
    end
  end
  always_ff @(posedge clk22) begin
    if (rst) begin
      vld <= '0;
      cd <= '0;
      hit <= '0;
      for (int i = 0; i < 4; i++) begin
        bx[i] <= '0;
        by[i] <= '0;
      end
    end else begin
      cd <= acc ? COOLDOWN : (cd != 4'd0) ? cd - 4'd1 : cd;
      hit <= hit_n;
      for (int i = 0; i < 4; i++) begin
        if (acc && sel[i]) begin
          vld[i] <= 1'b1;
          bx[i] <= reimux;
          by[i] <= reimuy - 10'd16;
        end else if (hs[i] || ret[i]) begin
          vld[i] <= 1'b0;
          bx[i] <= '0;
          by[i] <= '0;
        end else if (vld[i]) begin
          by[i] <= by[i] - SPEED;
        end
      end
    end
  end
`ifdef REIMU_BULLET_SCORE_EN
  logic [2:0] cnt;
  logic [16:0] sum;
  assign cnt = {2'b0, hit_n[0]} + {2'b0, hit_n[1]} + {2'b0, hit_n[2]} + {2'b0, hit_n[3]};
  assign sum = {1'b0, score} + {14'b0, cnt};
  always_ff @(posedge clk22)
    if (rst) score <= '0;
    else score <= sum[16] ? 16'hFFFF : sum[15:0];
`else
  assign score = 16'd0;
`endif
endmodule

// File: tb/tb_reimu_bullet.sv
// tb_reimu_bullet: scoreboard bench; stimulus queues expected outputs, a negedge monitor compares them.
module tb_reimu_bullet;
  logic clk22 = 0, rst = 1, fire = 0;
  logic [9:0] reimux = 0, reimuy = 0;
  logic [9:0] enmx1 = 0, enmx2 = 0, enmx3 = 0, enmx4 = 0, enmy1 = 0, enmy2 = 0, enmy3 = 0, enmy4 = 0;
  logic enm1 = 0, enm2 = 0, enm3 = 0, enm4 = 0;
  logic [9:0] bulletx1, bulletx2, bulletx3, bulletx4, bullety1, bullety2, bullety3, bullety4;
  logic [3:0] bullet_vld;
  logic hit1, hit2, hit3, hit4;
  logic [15:0] score;
  int cyc = 0, checks = 0, errors = 0;
`ifdef REIMU_BULLET_SCORE_EN
  localparam int SCE = 1;
`else
  localparam int SCE = 0;
`endif
  typedef struct {int cyc; int sel; int val; string name;} exp_t;
  exp_t q[$];

  reimu_bullet dut (
    .clk22(clk22), .rst(rst), .fire(fire), .reimux(reimux), .reimuy(reimuy),
    .enmx1(enmx1), .enmx2(enmx2), .enmx3(enmx3), .enmx4(enmx4),
    .enmy1(enmy1), .enmy2(enmy2), .enmy3(enmy3), .enmy4(enmy4),
    .enm1(enm1), .enm2(enm2), .enm3(enm3), .enm4(enm4),
    .bulletx1(bulletx1), .bulletx2(bulletx2), .bulletx3(bulletx3), .bulletx4(bulletx4),
    .bullety1(bullety1), .bullety2(bullety2), .bullety3(bullety3), .bullety4(bullety4),
    .bullet_vld(bullet_vld), .hit1(hit1), .hit2(hit2), .hit3(hit3), .hit4(hit4), .score(score)
  );

  always #5 clk22 = ~clk22;
  always @(posedge clk22) cyc <= cyc + 1;

  // sel: 0 vld, 1-4 x, 5-8 y, 9 hit vector, 10 score
  function automatic int act(int s);
    case (s)
      0: return int'(bullet_vld);
      1: return int'(bulletx1);
      2: return int'(bulletx2);
      3: return int'(bulletx3);
      4: return int'(bulletx4);
      5: return int'(bullety1);
      6: return int'(bullety2);
      7: return int'(bullety3);
      8: return int'(bullety4);
      9: return int'({hit4, hit3, hit2, hit1});
      default: return int'(score);
    endcase
  endfunction

  always @(negedge clk22) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc <= cyc) begin
        checks++;
        if (q[i].cyc != cyc) begin
          errors++;
          $display("FAIL %s: check missed at cycle %0d (scheduled %0d)", q[i].name, cyc, q[i].cyc);
        end else if (act(q[i].sel) != q[i].val) begin
          errors++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", q[i].name, act(q[i].sel), q[i].val, cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic ex(int d, int s, int v, string n);
    exp_t e;
    e.cyc = cyc + d; e.sel = s; e.val = v; e.name = n;
    q.push_back(e);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk22);
      #1;
    end
  endtask

  initial begin
    tick(2);
    ex(0, 0, 0, "rst_vld"); ex(0, 9, 0, "rst_hit"); ex(0, 10, 0, "rst_score"); ex(0, 1, 0, "rst_x1");
    rst = 0;
    tick(1);
    // held fire: slot1 then slot2 after cooldown
    fire = 1; reimux = 200; reimuy = 400;
    ex(1, 0, 1, "b_vld1"); ex(1, 1, 200, "b_x1"); ex(1, 5, 384, "b_y1"); ex(2, 5, 372, "b_y1_move");
    ex(5, 0, 1, "b_cooldown"); ex(6, 0, 3, "b_vld2"); ex(6, 6, 384, "b_y2"); ex(6, 5, 324, "b_y1_c6");
    tick(6);
    fire = 0; rst = 1;
    tick(1);
    rst = 0;
    // single bullet down to retire
    reimux = 50; reimuy = 100; fire = 1;
    ex(1, 5, 84, "c_y84"); ex(1, 1, 50, "c_x"); ex(7, 5, 12, "c_y12"); ex(7, 0, 1, "c_vld12");
    ex(8, 0, 0, "c_retired"); ex(8, 5, 0, "c_y_zero"); ex(8, 1, 0, "c_x_zero");
    tick(1);
    fire = 0;
    tick(8);
    fire = 1; reimuy = 23;
    ex(1, 0, 0, "c_low_y_drop");
    tick(1);
    fire = 0;
    tick(1);
    // hit on enemy 2
    enmx2 = 200; enmy2 = 300; enm2 = 1; reimux = 200; reimuy = 400; fire = 1;
    ex(7, 5, 312, "d_y312"); ex(7, 9, 0, "d_nohit_edge"); ex(8, 5, 300, "d_y300"); ex(8, 0, 1, "d_vld");
    ex(9, 9, 2, "d_hit2"); ex(9, 0, 0, "d_cleared"); ex(9, 10, SCE, "d_score"); ex(10, 9, 0, "d_pulse_end");
    tick(1);
    fire = 0;
    tick(9);
    enm2 = 0;
    // overlapping enemies: lowest index wins
    enmx1 = 200; enmy1 = 300; enm1 = 1; enmx3 = 200; enmy3 = 300; enm3 = 1; fire = 1;
    ex(9, 9, 1, "e_hit1_only"); ex(9, 0, 0, "e_cleared"); ex(9, 10, 2 * SCE, "e_score"); ex(10, 9, 0, "e_pulse_end");
    tick(1);
    fire = 0;
    tick(9);
    enm1 = 0;
    // near-origin enemy, dead enemy 4 overlapping too
    enmx3 = 5; enmy3 = 5; enmx4 = 2; enmy4 = 14; enm4 = 0; reimux = 2; reimuy = 30; fire = 1;
    ex(1, 0, 1, "e2_vld"); ex(1, 1, 2, "e2_x"); ex(1, 5, 14, "e2_y");
    ex(2, 9, 4, "e2_hit3"); ex(2, 0, 0, "e2_cleared"); ex(2, 10, 3 * SCE, "e2_score");
    tick(1);
    fire = 0;
    tick(2);
    enm3 = 0;
    tick(3);
    // fill all slots, drop while full, no refill of hit-freed slot same cycle
    reimux = 400; reimuy = 900; enmx1 = 400; enmy1 = 632; enm1 = 1; fire = 1;
    ex(16, 0, 15, "f_full"); ex(21, 0, 15, "f_drop1"); ex(22, 0, 15, "f_drop2"); ex(22, 5, 632, "f_y1");
    ex(23, 0, 14, "f_no_refill"); ex(23, 9, 1, "f_hit1"); ex(23, 1, 0, "f_x1_zero");
    ex(24, 0, 15, "f_refill"); ex(24, 5, 884, "f_refill_y"); ex(24, 10, 4 * SCE, "f_score");
    tick(23);
    enm1 = 0;
    tick(1);
    fire = 0;
    tick(1);
    // reset with slots in flight and a hit pending
    enmx2 = 400; enmy2 = 656; enm2 = 1; rst = 1;
    ex(1, 0, 0, "g_vld"); ex(1, 9, 0, "g_hit"); ex(1, 10, 0, "g_score"); ex(1, 6, 0, "g_y2"); ex(1, 2, 0, "g_x2");
    tick(1);
    rst = 0; enm2 = 0; fire = 1; reimux = 10; reimuy = 100;
    ex(1, 0, 1, "g_fire_vld"); ex(1, 1, 10, "g_fire_x"); ex(1, 5, 84, "g_fire_y"); ex(2, 9, 0, "g_nohit");
    tick(1);
    fire = 0;
    tick(3);
    if (q.size() != 0) begin
      checks += q.size();
      errors += q.size();
      $display("FAIL pending: %0d checks never reached, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached, expected finish");
    $fatal(1);
  end
endmodule
